// File: rtl/mc_processor.sv
// Multicycle 32-bit MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over a single
// request/ready memory port. An unsupported opcode or a misaligned data access parks the core in HALT.
module mc_processor #(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREG     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halted
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_R   = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                         OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR  = 6'h25, F_SLT = 6'h2A;

  state_t                state, state_nxt;
  logic [31:0]           pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [NREG-1:0][31:0] rf;

  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [31:0] simm, alu_nxt, pc_nxt, rd_a, rd_b, wb_data;
  logic [RW-1:0] rs_i, rt_i, rd_i, wr_i;
  logic [ADDR_W-1:0] addr_raw;
  logic legal, req_c, ir_ld, pc_ld, ab_ld, alu_ld, mdr_ld, rf_we;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign rs_i  = ir_q[21 +: RW];
  assign rt_i  = ir_q[16 +: RW];
  assign rd_i  = ir_q[11 +: RW];
  assign wr_i  = (op == OP_R) ? rd_i : rt_i;
  assign wb_data = (op == OP_LW) ? mdr_q : alu_q;

  // r0 is never written, but the read mux keeps it zero regardless
  assign rd_a = (rs_i == '0) ? 32'h0 : rf[rs_i];
  assign rd_b = (rt_i == '0) ? 32'h0 : rf[rt_i];

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                              legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_J, OP_BEQ, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_nxt = a_q + simm;
    if (op == OP_ORI) alu_nxt = a_q | {16'h0, imm};
    else if (op == OP_R) begin
      case (funct)
        F_SUB:   alu_nxt = a_q - b_q;
        F_AND:   alu_nxt = a_q & b_q;
        F_OR:    alu_nxt = a_q | b_q;
        F_SLT:   alu_nxt = {31'h0, $signed(a_q) < $signed(b_q)};
        default: alu_nxt = a_q + b_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    mem_we    = 1'b0;
    addr_raw  = pc_q[ADDR_W-1:0];
    retire    = 1'b0;
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_nxt    = pc_q;
    ab_ld     = 1'b0;
    alu_ld    = 1'b0;
    mdr_ld    = 1'b0;
    rf_we     = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_ld     = 1'b1;
          pc_ld     = 1'b1;
          pc_nxt    = pc_q + 32'd4;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        ab_ld     = 1'b1;
        state_nxt = legal ? EXEC : HALT;
      end
      EXEC: begin
        case (op)
          OP_R, OP_ORI: begin alu_ld = 1'b1; state_nxt = WB;  end
          OP_LW, OP_SW: begin alu_ld = 1'b1; state_nxt = MEM; end
          OP_BEQ: begin
            pc_ld     = (a_q == b_q);
            pc_nxt    = pc_q + {simm[29:0], 2'b00};
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          OP_J: begin
            pc_ld     = 1'b1;
            pc_nxt    = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          default: state_nxt = HALT;
        endcase
      end
      MEM: begin
        addr_raw = alu_q[ADDR_W-1:0];
        if (alu_q[1:0] != 2'b00) state_nxt = HALT;
        else begin
          req_c  = 1'b1;
          mem_we = (op == OP_SW);
          if (mem_ready) begin
            if (op == OP_SW) begin
              retire    = 1'b1;
              state_nxt = FETCH;
            end else begin
              mdr_ld    = 1'b1;
              state_nxt = WB;
            end
          end
        end
      end
      WB: begin
        rf_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // Reset lands in FETCH, so the request is masked until rst_n releases
  assign mem_req   = req_c & rst_n;
  assign mem_addr  = {addr_raw[ADDR_W-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      rf    <= '0;
    end else begin
      if (ir_ld)  ir_q  <= mem_rdata;
      if (pc_ld)  pc_q  <= pc_nxt;
      if (ab_ld) begin
        a_q <= rd_a;
        b_q <= rd_b;
      end
      if (alu_ld) alu_q <= alu_nxt;
      if (mdr_ld) mdr_q <= mem_rdata;
      if (rf_we && wr_i != '0) rf[wr_i] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mc_processor.sv
// Directed bench for mc_processor: wait-state memory model, retire-cycle log,
// and hand-computed expectations for each program.
module tb_mc_processor;

  localparam int AW = 16;

  logic          clk, rst_n;
  logic          mem_req, mem_we, mem_ready, retire, halted;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, pc_out;

  mc_processor #(.ADDR_W(AW), .RESET_PC(32'h0), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc_out(pc_out), .retire(retire), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  int          wait_n, wcnt, cyc, st_cnt;
  logic [AW-1:0] hold_addr, st_addr;
  logic [31:0] st_data;
  logic        st_valid;
  int          ret_q[$];
  int          checks = 0, errs = 0;

  // Single-entry store overlay lets lw observe an earlier sw
  assign mem_rdata = (st_valid && st_addr == mem_addr) ? st_data : mem[mem_addr[AW-1:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n) && (mem_addr != hold_addr);

  always @(posedge clk or negedge rst_n)
    if (!rst_n)                   wcnt <= 0;
    else if (!mem_req || mem_ready) wcnt <= 0;
    else                          wcnt <= wcnt + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_valid <= 1'b0;
      st_cnt   <= 0;
      st_addr  <= '0;
      st_data  <= '0;
    end else if (mem_req && mem_ready && mem_we) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr;
      st_data  <= mem_wdata;
      st_cnt   <= st_cnt + 1;
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc <= 0;
      ret_q.delete();
    end else begin
      if (retire) ret_q.push_back(cyc + 1);
      cyc <= cyc + 1;
    end

  function automatic logic [31:0] rty(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    wait_n    = 0;
    hold_addr = 16'h0001;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ret(input string tag, input int n, input int budget);
    int k = 0;
    while (ret_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ret_q.size(), n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    wait_n    = 0;
    hold_addr = 16'h0001;
    #2;

    // ori/ori/add, zero-wait: retires at 4, 8, 12
    hold_reset();
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    mem[0] = ity(6'h0D, 0, 1, 16'h0005);
    mem[1] = ity(6'h0D, 0, 2, 16'h0007);
    mem[2] = rty(1, 2, 3, 6'h20);
    mem[3] = ity(6'h04, 0, 0, 16'hFFFF);
    release_reset();
    #1;
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'h0);
    wait_ret("add_nret", 3, 40);
    chk("add_ret0", ret_q[0], 4);
    chk("add_ret1", ret_q[1], 8);
    chk("add_ret2", ret_q[2], 12);
    chk("add_r3", dut.rf[3], 32'h0000_000C);
    chk("add_pc", pc_out, 32'h0000_000C);

    // sw then lw with 3 wait cycles per access
    hold_reset();
    wait_n = 3;
    mem[0]  = {6'h02, 26'h40};
    mem[64] = ity(6'h0D, 0, 3, 16'h000C);
    mem[65] = ity(6'h2B, 0, 3, 16'h0008);
    mem[66] = ity(6'h23, 0, 4, 16'h0008);
    mem[67] = ity(6'h04, 0, 0, 16'hFFFF);
    release_reset();
    wait_ret("mem_nret", 4, 80);
    chk("mem_ret_j", ret_q[0], 6);
    chk("mem_ret_ori", ret_q[1], 13);
    chk("mem_ret_sw", ret_q[2], 23);
    chk("mem_ret_lw", ret_q[3], 34);
    chk("sw_count", st_cnt, 1);
    chk("sw_addr", {16'h0, st_addr}, 32'h8);
    chk("sw_data", st_data, 32'h0000_000C);
    chk("lw_r4", dut.rf[4], 32'h0000_000C);

    // beq self-loop every 3 cycles
    hold_reset();
    mem[0] = ity(6'h0D, 0, 1, 16'h0001);
    mem[1] = ity(6'h04, 1, 1, 16'hFFFF);
    release_reset();
    wait_ret("loop_nret", 3, 40);
    chk("loop_ret1", ret_q[1], 7);
    chk("loop_ret2", ret_q[2], 10);
    chk("loop_pc", pc_out, 32'h4);

    // beq not taken, beq taken forward over one instruction
    hold_reset();
    mem[0] = ity(6'h0D, 0, 1, 16'h0001);
    mem[1] = ity(6'h0D, 0, 2, 16'h0002);
    mem[2] = ity(6'h04, 1, 2, 16'h0005);
    mem[3] = ity(6'h04, 0, 0, 16'h0001);
    mem[4] = ity(6'h0D, 0, 8, 16'h0BAD);
    mem[5] = ity(6'h0D, 0, 7, 16'h0077);
    mem[6] = ity(6'h04, 0, 0, 16'hFFFF);
    release_reset();
    wait_ret("br_nret", 5, 60);
    chk("br_nt_ret", ret_q[2], 11);
    chk("br_tk_ret", ret_q[3], 14);
    chk("br_ori_ret", ret_q[4], 18);
    chk("br_r7", dut.rf[7], 32'h77);
    chk("br_r8_skipped", dut.rf[8], 32'h0);

    // unsupported opcode halts from DECODE
    hold_reset();
    mem[0] = 32'hFC00_0000;
    release_reset();
    repeat (2) @(negedge clk);
    chk("bad_op_halted", {31'h0, halted}, 32'h1);
    repeat (4) @(negedge clk);
    chk("bad_op_req", {31'h0, mem_req}, 32'h0);
    chk("bad_op_nret", ret_q.size(), 0);
    chk("bad_op_pc", pc_out, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_clear", {31'h0, halted}, 32'h0);

    // unsupported funct halts too
    hold_reset();
    mem[0] = rty(1, 2, 3, 6'h21);
    release_reset();
    repeat (2) @(negedge clk);
    chk("bad_fn_halted", {31'h0, halted}, 32'h1);

    // misaligned lw: no access in MEM, then halted
    hold_reset();
    mem[0] = ity(6'h23, 0, 4, 16'h0006);
    release_reset();
    repeat (3) @(negedge clk);
    chk("mis_mem_req", {31'h0, mem_req}, 32'h0);
    chk("mis_not_yet", {31'h0, halted}, 32'h0);
    @(negedge clk);
    chk("mis_halted", {31'h0, halted}, 32'h1);
    repeat (3) @(negedge clk);
    chk("mis_req_after", {31'h0, mem_req}, 32'h0);
    chk("mis_nret", ret_q.size(), 0);
    chk("mis_r4", dut.rf[4], 32'h0);

    // reset mid-access aborts a stalled lw
    hold_reset();
    mem[0]    = ity(6'h23, 0, 4, 16'h0010);
    mem[4]    = 32'hDEAD_BEEF;
    hold_addr = 16'h0010;
    release_reset();
    repeat (3) @(negedge clk);
    chk("abort_req_on", {31'h0, mem_req}, 32'h1);
    chk("abort_addr", {16'h0, mem_addr}, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_req_off", {31'h0, mem_req}, 32'h0);
    chk("abort_pc", pc_out, 32'h0);
    chk("abort_r4", dut.rf[4], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_refetch_req", {31'h0, mem_req}, 32'h1);
    chk("abort_refetch_addr", {16'h0, mem_addr}, 32'h0);
    hold_addr = 16'h0001;
    wait_ret("abort_nret", 1, 20);
    chk("abort_lw_ret", ret_q[0], 5);
    chk("abort_lw_r4", dut.rf[4], 32'hDEAD_BEEF);

    // r0 immutability, signed slt, sub/and/or
    hold_reset();
    mem[0]  = ity(6'h0D, 0, 0, 16'hFFFF);
    mem[1]  = ity(6'h23, 0, 6, 16'h0040);
    mem[2]  = rty(6, 0, 5, 6'h2A);
    mem[3]  = rty(0, 0, 9, 6'h20);
    mem[4]  = rty(0, 6, 11, 6'h2A);
    mem[5]  = ity(6'h0D, 0, 1, 16'h00F3);
    mem[6]  = rty(0, 1, 12, 6'h22);
    mem[7]  = ity(6'h0D, 0, 2, 16'h0F0F);
    mem[8]  = rty(1, 2, 13, 6'h24);
    mem[9]  = rty(1, 2, 14, 6'h25);
    mem[10] = ity(6'h04, 0, 0, 16'hFFFF);
    mem[16] = 32'h8000_0000;
    release_reset();
    wait_ret("alu_nret", 10, 80);
    chk("alu_lw_ret", ret_q[1], 9);
    chk("alu_r6", dut.rf[6], 32'h8000_0000);
    chk("slt_r5", dut.rf[5], 32'h1);
    chk("r0_add_r9", dut.rf[9], 32'h0);
    chk("slt_r11", dut.rf[11], 32'h0);
    chk("sub_r12", dut.rf[12], 32'hFFFF_FF0D);
    chk("and_r13", dut.rf[13], 32'h0000_0003);
    chk("or_r14", dut.rf[14], 32'h0000_0FFF);

    // PC wrap across the top of the address space
    hold_reset();
    mem[0]      = {6'h02, 26'h3FFF};
    mem[16383]  = ity(6'h0D, 0, 15, 16'h1234);
    release_reset();
    repeat (3) @(negedge clk);
    chk("wrap_top_addr", {16'h0, mem_addr}, 32'hFFFC);
    chk("wrap_top_pc", pc_out, 32'h0000_FFFC);
    repeat (4) @(negedge clk);
    chk("wrap_zero_addr", {16'h0, mem_addr}, 32'h0);
    chk("wrap_pc", pc_out, 32'h0001_0000);
    chk("wrap_r15", dut.rf[15], 32'h1234);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
